// File: rtl/conv_axi_pkg.sv
// conv_axi_pkg: shared FSM encoding and AXI constants for the convolution engine's AXI blocks
package conv_axi_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   function automatic logic [2:0] axi_size(input int bytes);
      return 3'($clog2(bytes));
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int WIDTH_RQ = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [WIDTH_RQ-1:0] ptr,
   output logic [NUM_REQ-1:0]  gnt,
   output logic [WIDTH_RQ-1:0] idx
);
   logic [WIDTH_RQ-1:0] j;
   // walk from the farthest offset down so the nearest requester wins last
   always_comb begin
      gnt = '0;
      idx = '0;
      j = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = WIDTH_RQ'((int'(ptr) + k) % NUM_REQ);
         if (req[j]) begin
            gnt = '0;
            gnt[j] = 1'b1;
            idx = j;
         end
      end
   end
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin sharing of one AXI4 read master among NUM_REQ requesters
module axi_rd_arbiter
   import conv_axi_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int WIDTH_ID = 4,
   parameter int WIDTH_AD = 32,
   parameter int WIDTH_DA = 32,
   parameter int WIDTH_RQ = $clog2(NUM_REQ)
) (
   input  logic                         ARESET,
   input  logic                         ACLK,
   input  logic [NUM_REQ-1:0]           S_ARVALID,
   output logic [NUM_REQ-1:0]           S_ARREADY,
   input  logic [NUM_REQ*WIDTH_ID-1:0]  S_ARID,
   input  logic [NUM_REQ*WIDTH_AD-1:0]  S_ARADDR,
   input  logic [NUM_REQ*8-1:0]         S_ARLEN,
   input  logic [NUM_REQ*3-1:0]         S_ARSIZE,
   input  logic [NUM_REQ*2-1:0]         S_ARBURST,
   output logic [NUM_REQ-1:0]           S_RVALID,
   input  logic [NUM_REQ-1:0]           S_RREADY,
   output logic [WIDTH_ID-1:0]          S_RID,
   output logic [WIDTH_DA-1:0]          S_RDATA,
   output logic [1:0]                   S_RRESP,
   output logic                         S_RLAST,
   output logic [WIDTH_ID-1:0]          M_ARID,
   output logic [WIDTH_AD-1:0]          M_ARADDR,
   output logic [7:0]                   M_ARLEN,
   output logic [2:0]                   M_ARSIZE,
   output logic [1:0]                   M_ARBURST,
   output logic                         M_ARVALID,
   input  logic                         M_ARREADY,
   input  logic [WIDTH_ID-1:0]          M_RID,
   input  logic [WIDTH_DA-1:0]          M_RDATA,
   input  logic [1:0]                   M_RRESP,
   input  logic                         M_RLAST,
   input  logic                         M_RVALID,
   output logic                         M_RREADY,
   output logic                         BUSY,
   output logic [WIDTH_RQ-1:0]          GRANT
);
   state_t state;
   logic [WIDTH_RQ-1:0] ptr, win_idx;
   logic [NUM_REQ-1:0] win_oh;
   rr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH_RQ(WIDTH_RQ)) u_rr (
      .req(S_ARVALID),
      .ptr(ptr),
      .gnt(win_oh),
      .idx(win_idx)
   );
   // ready is gated by reset so a held request is never acknowledged while reset is active
   assign S_ARREADY = (state == ST_IDLE && !ARESET) ? win_oh : '0;
   assign S_RVALID  = (state == ST_DATA && M_RVALID) ? (NUM_REQ'(1) << GRANT) : '0;
   assign M_RREADY  = (state == ST_DATA) && S_RREADY[GRANT];
   assign S_RID     = M_RID;
   assign S_RDATA   = M_RDATA;
   assign S_RRESP   = M_RRESP;
   assign S_RLAST   = M_RLAST;
   assign BUSY      = state != ST_IDLE;
   always_ff @(posedge ACLK or posedge ARESET)
      if (ARESET) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         GRANT     <= '0;
         M_ARVALID <= 1'b0;
         M_ARID    <= '0;
         M_ARADDR  <= '0;
         M_ARLEN   <= '0;
         M_ARSIZE  <= '0;
         M_ARBURST <= '0;
      end else
         case (state)
            ST_IDLE:
               if (|S_ARVALID) begin
                  M_ARID    <= S_ARID[win_idx*WIDTH_ID +: WIDTH_ID];
                  M_ARADDR  <= S_ARADDR[win_idx*WIDTH_AD +: WIDTH_AD];
                  M_ARLEN   <= S_ARLEN[win_idx*8 +: 8];
                  M_ARSIZE  <= S_ARSIZE[win_idx*3 +: 3];
                  M_ARBURST <= S_ARBURST[win_idx*2 +: 2];
                  GRANT     <= win_idx;
                  M_ARVALID <= 1'b1;
                  state     <= ST_ADDR;
               end
            ST_ADDR:
               if (M_ARREADY) begin
                  M_ARVALID <= 1'b0;
                  state     <= ST_DATA;
               end
            ST_DATA:
               if (M_RVALID && M_RREADY && M_RLAST) begin
                  ptr   <= (GRANT == WIDTH_RQ'(NUM_REQ - 1)) ? '0 : GRANT + 1'b1;
                  state <= ST_IDLE;
               end
            default: state <= ST_IDLE;
         endcase
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: randomized requesters and slave checked against a transaction-level model
module tb_axi_rd_arbiter;
   import conv_axi_pkg::*;
   localparam int N = 3, IW = 4, AW = 32, DW = 32, RW = $clog2(N);
   logic ACLK = 1'b0, ARESET = 1'b1;
   logic [N-1:0] S_ARVALID = '0, S_RREADY = '0, S_ARREADY, S_RVALID;
   logic [N*IW-1:0] S_ARID = '0;
   logic [N*AW-1:0] S_ARADDR = '0;
   logic [N*8-1:0] S_ARLEN = '0;
   logic [N*3-1:0] S_ARSIZE = '0;
   logic [N*2-1:0] S_ARBURST = '0;
   logic [IW-1:0] S_RID, M_ARID, M_RID = '0;
   logic [DW-1:0] S_RDATA, M_RDATA = '0;
   logic [1:0] S_RRESP, M_ARBURST, M_RRESP = '0;
   logic S_RLAST, M_ARVALID, M_RREADY, BUSY;
   logic M_ARREADY = 1'b0, M_RLAST = 1'b0, M_RVALID = 1'b0;
   logic [AW-1:0] M_ARADDR;
   logic [7:0] M_ARLEN;
   logic [2:0] M_ARSIZE;
   logic [RW-1:0] GRANT;

   axi_rd_arbiter #(.NUM_REQ(N), .WIDTH_ID(IW), .WIDTH_AD(AW), .WIDTH_DA(DW)) dut (
      .ARESET(ARESET), .ACLK(ACLK),
      .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY), .S_ARID(S_ARID), .S_ARADDR(S_ARADDR),
      .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
      .S_RVALID(S_RVALID), .S_RREADY(S_RREADY), .S_RID(S_RID), .S_RDATA(S_RDATA),
      .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
      .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
      .M_ARBURST(M_ARBURST), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
      .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
      .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .BUSY(BUSY), .GRANT(GRANT)
   );

   always #5 ACLK = ~ACLK;

   int errs = 0, checks = 0;
   bit pend[N];
   logic [AW-1:0] raddr[N];
   logic [7:0] rlen[N];
   logic [IW-1:0] rid[N];
   int gcnt[N];
   bit idle = 1'b1, arp = 1'b0, dat = 1'b0, s_hold = 1'b0;
   int ptr = 0, gr = 0, k = 0, s_left = 0, done = 0;
   logic [AW-1:0] c_addr = '0;
   logic [7:0] c_len = '0;
   logic [IW-1:0] c_id = '0;
   int p_req, max_len, p_drop, p_arrdy, p_rvalid, p_rready, p_ill;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // one clock: drive at the falling edge, check 1ns later, then advance the model past the rising edge
   task automatic step();
      int w;
      for (int r = 0; r < N; r++) begin
         if (!pend[r] && $urandom_range(99) < p_req) begin
            pend[r] = 1'b1;
            raddr[r] = $urandom & 32'hFFFF_FF00;
            rlen[r] = 8'($urandom_range(max_len));
            rid[r] = IW'($urandom);
         end else if (pend[r] && $urandom_range(99) < p_drop) pend[r] = 1'b0;
         S_ARVALID[r] = pend[r];
         S_ARADDR[r*AW +: AW] = raddr[r];
         S_ARLEN[r*8 +: 8] = rlen[r];
         S_ARID[r*IW +: IW] = rid[r];
         S_ARSIZE[r*3 +: 3] = axi_size(DW / 8);
         S_ARBURST[r*2 +: 2] = BURST_INCR;
         S_RREADY[r] = $urandom_range(99) < p_rready;
      end
      M_ARREADY = $urandom_range(99) < p_arrdy;
      if (s_left > 0) begin
         if (!s_hold) begin
            M_RVALID = $urandom_range(99) < p_rvalid;
            M_RRESP = ($urandom_range(3) == 0) ? RESP_SLVERR : RESP_OKAY;
         end
         M_RDATA = DW'(c_addr + k);
         M_RLAST = s_left == 1;
         M_RID = c_id;
      end else begin
         M_RVALID = $urandom_range(99) < p_ill;
         M_RLAST = $urandom_range(1) == 1;
         M_RDATA = $urandom;
         M_RRESP = RESP_DECERR;
      end
      #1;
      w = -1;
      if (idle)
         for (int i = 0; i < N; i++)
            if (w < 0 && pend[(ptr + i) % N]) w = (ptr + i) % N;
      chk("s_arready", S_ARREADY, (w >= 0) ? (64'd1 << w) : 64'd0);
      chk("busy", BUSY, !idle);
      chk("m_arvalid", M_ARVALID, arp);
      if (!idle) chk("grant", GRANT, gr);
      if (arp) begin
         chk("m_araddr", M_ARADDR, c_addr);
         chk("m_arlen", M_ARLEN, c_len);
         chk("m_arid", M_ARID, c_id);
         chk("m_arsize", M_ARSIZE, axi_size(DW / 8));
         chk("m_arburst", M_ARBURST, BURST_INCR);
      end
      chk("s_rvalid", S_RVALID, (dat && M_RVALID) ? (64'd1 << gr) : 64'd0);
      chk("m_rready", M_RREADY, dat && S_RREADY[gr]);
      if (dat && M_RVALID && S_RREADY[gr]) begin
         chk("s_rdata", S_RDATA, c_addr + k);
         chk("s_rlast", S_RLAST, k == c_len);
         chk("s_rresp", S_RRESP, M_RRESP);
         chk("s_rid", S_RID, c_id);
      end
      if (w >= 0) begin
         gr = w;
         idle = 1'b0;
         arp = 1'b1;
         c_addr = raddr[w];
         c_len = rlen[w];
         c_id = rid[w];
         pend[w] = 1'b0;
         gcnt[w]++;
      end else if (arp) begin
         if (M_ARREADY) begin
            arp = 1'b0;
            dat = 1'b1;
            s_left = c_len + 1;
            k = 0;
            s_hold = 1'b0;
         end
      end else if (dat) begin
         if (M_RVALID && S_RREADY[gr]) begin
            k++;
            s_left--;
            s_hold = 1'b0;
            if (s_left == 0) begin
               dat = 1'b0;
               idle = 1'b1;
               ptr = (gr + 1) % N;
               done++;
            end
         end else s_hold = M_RVALID;
      end
      @(negedge ACLK);
   endtask

   initial begin
      int mx, mn;
      p_req = 100; max_len = 0; p_drop = 0; p_arrdy = 100; p_rvalid = 100; p_rready = 100; p_ill = 0;
      for (int r = 0; r < N; r++) begin
         pend[r] = 1'b1;
         raddr[r] = AW'(32'h1000 * (r + 1));
         rlen[r] = 8'd0;
         rid[r] = IW'(r);
         gcnt[r] = 0;
         S_ARADDR[r*AW +: AW] = raddr[r];
         S_ARID[r*IW +: IW] = rid[r];
      end
      S_ARVALID = '1;
      repeat (3) @(negedge ACLK);
      chk("rst_s_arready", S_ARREADY, 0);
      chk("rst_m_arvalid", M_ARVALID, 0);
      chk("rst_m_araddr", M_ARADDR, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_grant", GRANT, 0);
      chk("rst_m_rready", M_RREADY, 0);
      chk("rst_s_rvalid", S_RVALID, 0);
      ARESET = 1'b0;
      repeat (60) step();
      mx = gcnt[0];
      mn = gcnt[0];
      for (int r = 1; r < N; r++) begin
         mx = (gcnt[r] > mx) ? gcnt[r] : mx;
         mn = (gcnt[r] < mn) ? gcnt[r] : mn;
      end
      chk("fairness", (mx - mn <= 1) && (mn >= 5), 1);
      p_req = 30; max_len = 7; p_drop = 3; p_arrdy = 50; p_rvalid = 70; p_rready = 60; p_ill = 20;
      repeat (3000) step();
      max_len = 15;
      for (int i = 0; i < 2000 && !(dat && k >= 2 && s_left > 0); i++) step();
      chk("reset_window", dat && k >= 2, 1);
      ARESET = 1'b1;
      M_RVALID = 1'b0;
      #1;
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_m_rready", M_RREADY, 0);
      chk("mid_rst_s_rvalid", S_RVALID, 0);
      chk("mid_rst_s_arready", S_ARREADY, 0);
      chk("mid_rst_grant", GRANT, 0);
      idle = 1'b1; arp = 1'b0; dat = 1'b0; ptr = 0; gr = 0; s_left = 0; s_hold = 1'b0;
      #1 ARESET = 1'b0;
      repeat (500) step();
      chk("bursts_done", done >= 50, 1);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
